// File: rtl/orbtrace_frame_pkg.sv
// Shared definitions for the orbtrace frame serialiser/deserialiser pair:
// status frame framing constants, field positions and small helpers.
package orbtrace_frame_pkg;

    localparam int FRAME_BYTES = 16;

    localparam logic [7:0]  STATUS_HDR = 8'hA6;
    localparam logic [31:0] STATUS_TRL = 32'hFFFFFF7F;

    // Status field bit positions within the 128-bit frame (byte 0 at [127:120]).
    localparam int STAT_FRAMES_CNT_MSB   = 119;
    localparam int STAT_FRAMES_CNT_LSB   = 104;
    localparam int STAT_SYNC_COUNT_MSB   = 103;
    localparam int STAT_SYNC_COUNT_LSB   = 88;
    localparam int STAT_LEDS_MSB         = 87;
    localparam int STAT_LEDS_LSB         = 80;
    localparam int STAT_LOST_FRAMES_MSB  = 79;
    localparam int STAT_LOST_FRAMES_LSB  = 64;
    localparam int STAT_TOTAL_FRAMES_MSB = 63;
    localparam int STAT_TOTAL_FRAMES_LSB = 32;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } rx_state_t;

    typedef struct packed {
        logic [15:0] frames_cnt;
        logic [15:0] sync_count;
        logic [7:0]  leds;
        logic [15:0] lost_frames;
        logic [31:0] total_frames;
    } status_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/status_frame_decode.sv
// Combinational status frame recogniser: flags a 16-byte window carrying the
// status header/trailer and splits out its statistic fields.
module status_frame_decode
    import orbtrace_frame_pkg::*;
(
    input  logic [127:0] i_window,
    output logic         o_match,
    output status_t      o_status
);

    assign o_match = (i_window[127:120] == STATUS_HDR) && (i_window[31:0] == STATUS_TRL);

    assign o_status = '{
        frames_cnt:   i_window[STAT_FRAMES_CNT_MSB:STAT_FRAMES_CNT_LSB],
        sync_count:   i_window[STAT_SYNC_COUNT_MSB:STAT_SYNC_COUNT_LSB],
        leds:         i_window[STAT_LEDS_MSB:STAT_LEDS_LSB],
        lost_frames:  i_window[STAT_LOST_FRAMES_MSB:STAT_LOST_FRAMES_LSB],
        total_frames: i_window[STAT_TOTAL_FRAMES_MSB:STAT_TOTAL_FRAMES_LSB]
    };

endmodule

// File: rtl/serial_to_frame.sv
// Byte stream to 128-bit frame reassembler: hunts for status frames to
// establish alignment, then emits data frames and decodes status statistics.
module serial_to_frame
    import orbtrace_frame_pkg::*;
#(
    parameter int unsigned SYNC_INTERVAL = 2,
    parameter int unsigned IDLE_TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   DataVal,
    input  logic         DataReady,
    output logic [127:0] Frame,
    output logic         FrameValid,
    output logic         Locked,
    output logic         StatValid,
    output logic [15:0]  StatFramesCnt,
    output logic [15:0]  StatSyncCount,
    output logic [7:0]   StatLeds,
    output logic [15:0]  StatLostFrames,
    output logic [31:0]  StatTotalFrames,
    output logic [15:0]  LockLosses,
    output logic [15:0]  PartialDrops
);

    localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

    rx_state_t    r_state, w_state_nx;
    // Only the 15 most recent bytes need storing; the 16th is the incoming byte.
    logic [119:0] r_hist;
    logic [3:0]   r_byte_cnt;
    logic [15:0]  r_since;
    logic [31:0]  r_idle_cnt;

    logic [127:0] w_window;
    logic         w_match;
    status_t      w_status;
    logic [15:0]  w_since_inc;
    logic         w_stat_load, w_frame_load, w_lock_loss;
    logic         w_cnt_clr, w_since_clr, w_since_step, w_drop;

    assign w_window    = {r_hist, DataVal};
    assign w_since_inc = sat_inc16(r_since);
    assign Locked      = (r_state == ST_LOCKED);

    status_frame_decode u_decode (
        .i_window (w_window),
        .o_match  (w_match),
        .o_status (w_status)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_HUNT;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path can infer a latch.
        w_state_nx   = r_state;
        w_stat_load  = 1'b0;
        w_frame_load = 1'b0;
        w_lock_loss  = 1'b0;
        w_cnt_clr    = 1'b0;
        w_since_clr  = 1'b0;
        w_since_step = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (DataReady && w_match) begin
                    w_state_nx  = ST_LOCKED;
                    w_stat_load = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_since_clr = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (DataReady) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        if (w_match) begin
                            w_stat_load = 1'b1;
                            w_since_clr = 1'b1;
                        end else begin
                            w_frame_load = 1'b1;
                            w_since_step = 1'b1;
                            if ({16'd0, w_since_inc} > SYNC_INTERVAL) begin
                                w_state_nx  = ST_HUNT;
                                w_lock_loss = 1'b1;
                            end
                        end
                    end
                end else if (r_byte_cnt != 4'd0 && r_idle_cnt == IDLE_TIMEOUT - 1) begin
                    // A byte on this cycle would have taken the branch above instead.
                    w_drop    = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            default: w_state_nx = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_hist          <= '0;
            r_byte_cnt      <= '0;
            r_since         <= '0;
            r_idle_cnt      <= '0;
            Frame           <= '0;
            FrameValid      <= 1'b0;
            StatValid       <= 1'b0;
            StatFramesCnt   <= '0;
            StatSyncCount   <= '0;
            StatLeds        <= '0;
            StatLostFrames  <= '0;
            StatTotalFrames <= '0;
            LockLosses      <= '0;
            PartialDrops    <= '0;
        end else begin
            FrameValid <= w_frame_load;
            StatValid  <= w_stat_load;

            if (DataReady) r_hist <= w_window[119:0];

            if (w_cnt_clr)                          r_byte_cnt <= '0;
            else if (DataReady && r_state == ST_LOCKED) r_byte_cnt <= r_byte_cnt + 4'd1;

            if (DataReady || r_state != ST_LOCKED) r_idle_cnt <= '0;
            else if (r_idle_cnt != '1)             r_idle_cnt <= r_idle_cnt + 32'd1;

            if (w_since_clr)       r_since <= '0;
            else if (w_since_step) r_since <= w_since_inc;

            if (w_frame_load) Frame <= w_window;

            if (w_stat_load) begin
                StatFramesCnt   <= w_status.frames_cnt;
                StatSyncCount   <= w_status.sync_count;
                StatLeds        <= w_status.leds;
                StatLostFrames  <= w_status.lost_frames;
                StatTotalFrames <= w_status.total_frames;
            end

            if (w_lock_loss) LockLosses   <= sat_inc16(LockLosses);
            if (w_drop)      PartialDrops <= sat_inc16(PartialDrops);
        end
    end

endmodule

// File: tb/tb_serial_to_frame.sv
// Scoreboard bench for serial_to_frame: a byte-level reference model predicts
// each strobe, and a negedge monitor compares whatever the DUT presents.
module tb_serial_to_frame;

    localparam int unsigned SYNC_INTERVAL = 2;
    localparam int unsigned IDLE_TIMEOUT  = 1024;

    logic         clk;
    logic         rst;
    logic [7:0]   DataVal;
    logic         DataReady;
    logic [127:0] Frame;
    logic         FrameValid;
    logic         Locked;
    logic         StatValid;
    logic [15:0]  StatFramesCnt;
    logic [15:0]  StatSyncCount;
    logic [7:0]   StatLeds;
    logic [15:0]  StatLostFrames;
    logic [31:0]  StatTotalFrames;
    logic [15:0]  LockLosses;
    logic [15:0]  PartialDrops;

    serial_to_frame #(
        .SYNC_INTERVAL (SYNC_INTERVAL),
        .IDLE_TIMEOUT  (IDLE_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .DataVal         (DataVal),
        .DataReady       (DataReady),
        .Frame           (Frame),
        .FrameValid      (FrameValid),
        .Locked          (Locked),
        .StatValid       (StatValid),
        .StatFramesCnt   (StatFramesCnt),
        .StatSyncCount   (StatSyncCount),
        .StatLeds        (StatLeds),
        .StatLostFrames  (StatLostFrames),
        .StatTotalFrames (StatTotalFrames),
        .LockLosses      (LockLosses),
        .PartialDrops    (PartialDrops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_stat;
        logic [127:0] win;
        bit           locked;
        int           ll;
        int           pd;
    } ev_t;

    ev_t          exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] last_frame = '0;

    // Reference model: last 16 bytes seen, lock flag, position in frame.
    logic [7:0] hist[$];
    bit         m_locked;
    int         m_pos, m_since, m_idle, m_ll, m_pd;

    localparam logic [127:0] ST_A = 128'hA601_2300_053C_0002_0000_0010_FFFF_FF7F;
    localparam logic [127:0] D0   = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    localparam logic [127:0] D1   = 128'h1011_1213_1415_1617_1819_1A1B_1C1D_1E1F;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hist_is_status();
        return hist[0] == 8'hA6 && hist[12] == 8'hFF && hist[13] == 8'hFF &&
               hist[14] == 8'hFF && hist[15] == 8'h7F;
    endfunction

    function automatic logic [127:0] hist_window();
        logic [127:0] w = '0;
        foreach (hist[i]) w = {w[119:0], hist[i]};
        return w;
    endfunction

    task automatic push_event(input bit is_stat);
        ev_t e;
        e.is_stat = is_stat;
        e.win     = hist_window();
        e.locked  = m_locked;
        e.ll      = m_ll;
        e.pd      = m_pd;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        hist.delete();
        repeat (16) hist.push_back(8'h00);
        m_locked = 0; m_pos = 0; m_since = 0; m_idle = 0; m_ll = 0; m_pd = 0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        hist.push_back(b);
        void'(hist.pop_front());
        m_idle = 0;
        if (!m_locked) begin
            if (hist_is_status()) begin
                m_locked = 1; m_pos = 0; m_since = 0;
                push_event(1);
            end
        end else begin
            m_pos++;
            if (m_pos == 16) begin
                m_pos = 0;
                if (hist_is_status()) begin
                    m_since = 0;
                    push_event(1);
                end else begin
                    if (m_since < 65535) m_since++;
                    if (m_since > int'(SYNC_INTERVAL)) begin
                        m_locked = 0;
                        if (m_ll < 65535) m_ll++;
                    end
                    push_event(0);
                end
            end
        end
    endtask

    task automatic model_idle();
        if (m_locked) begin
            m_idle++;
            if (m_pos != 0 && m_idle == int'(IDLE_TIMEOUT)) begin
                m_pos = 0;
                if (m_pd < 65535) m_pd++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        DataVal   = b;
        DataReady = 1'b1;
        @(posedge clk);
        model_byte(b);
        #1;
        DataReady = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_idle();
            #1;
        end
    endtask

    task automatic send_frame(input logic [127:0] f, input int max_gap);
        for (int i = 0; i < 16; i++) begin
            send_byte(f[127 - 8*i -: 8]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_frame",        Frame, '0);
        check("rst_frame_valid",  128'(FrameValid), '0);
        check("rst_locked",       128'(Locked), '0);
        check("rst_stat_valid",   128'(StatValid), '0);
        check("rst_frames_cnt",   128'(StatFramesCnt), '0);
        check("rst_sync_count",   128'(StatSyncCount), '0);
        check("rst_leds",         128'(StatLeds), '0);
        check("rst_lost_frames",  128'(StatLostFrames), '0);
        check("rst_total_frames", 128'(StatTotalFrames), '0);
        check("rst_lock_losses",  128'(LockLosses), '0);
        check("rst_partial_drops",128'(PartialDrops), '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        DataReady = 1'b0;
        rst       = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
    endtask

    function automatic logic [127:0] rand_status();
        logic [127:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        f[127:120] = 8'hA6;
        f[31:0]    = 32'hFFFFFF7F;
        return f;
    endfunction

    // Monitor: every strobe must match the oldest prediction, due the same cycle.
    always @(negedge clk) begin
        ev_t e;
        if (rst) begin
            last_frame = '0;
        end else if (FrameValid || StatValid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 128'({FrameValid, StatValid}), '0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 128'({FrameValid, StatValid}), 128'(e.is_stat ? 2'b01 : 2'b10));
                if (e.is_stat) begin
                    check("stat_frames_cnt",   128'(StatFramesCnt),   128'(e.win[119:104]));
                    check("stat_sync_count",   128'(StatSyncCount),   128'(e.win[103:88]));
                    check("stat_leds",         128'(StatLeds),        128'(e.win[87:80]));
                    check("stat_lost_frames",  128'(StatLostFrames),  128'(e.win[79:64]));
                    check("stat_total_frames", 128'(StatTotalFrames), 128'(e.win[63:32]));
                    check("frame_hold",        Frame, last_frame);
                end else begin
                    check("frame", Frame, e.win);
                    last_frame = e.win;
                end
                check("locked",        128'(Locked), 128'(e.locked));
                check("lock_losses",   128'(LockLosses), 128'(e.ll));
                check("partial_drops", 128'(PartialDrops), 128'(e.pd));
            end
        end else if (exp_q.size() != 0) begin
            check("missing_strobe", '0, 128'(1));
            void'(exp_q.pop_front());
        end
    end

    initial begin
        int r;
        rst       = 1'b1;
        DataReady = 1'b0;
        DataVal   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        idle(2);

        // Lock on the reference status frame.
        send_frame(ST_A, 0);
        idle(2);
        check("lock_locked",       128'(Locked), 128'(1));
        check("lock_frames_cnt",   128'(StatFramesCnt), 128'(16'h0123));
        check("lock_sync_count",   128'(StatSyncCount), 128'(16'd5));
        check("lock_leds",         128'(StatLeds), 128'(8'h3C));
        check("lock_lost_frames",  128'(StatLostFrames), 128'(16'd2));
        check("lock_total_frames", 128'(StatTotalFrames), 128'(32'h10));

        // Status, two data frames, status: lock holds.
        send_frame(ST_A, 0);
        send_frame(D0, 0);
        send_frame(D1, 0);
        send_frame(ST_A, 0);
        idle(2);
        check("sync_ok_locked", 128'(Locked), 128'(1));
        check("sync_ok_frame",  Frame, D1);

        // Three data frames after status exceeds the interval.
        send_frame(ST_A, 0);
        send_frame(D0, 0);
        send_frame(D1, 0);
        send_frame(D0, 0);
        idle(2);
        check("loss_locked",      128'(Locked), '0);
        check("loss_lock_losses", 128'(LockLosses), 128'(1));

        // Garbage then status at full rate.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 8'hA5)));
        send_frame(ST_A, 0);
        idle(2);
        check("relock_locked", 128'(Locked), 128'(1));

        // Partial frame discarded by idle timeout, next frame intact.
        for (int i = 0; i < 7; i++) send_byte(8'(i + 8'h40));
        idle(IDLE_TIMEOUT + 4);
        check("timeout_drops", 128'(PartialDrops), 128'(1));
        send_frame(D0, 0);
        // One cycle short of the timeout: the byte wins.
        for (int i = 0; i < 7; i++) send_byte(D1[127 - 8*i -: 8]);
        idle(IDLE_TIMEOUT - 1);
        for (int i = 7; i < 16; i++) send_byte(D1[127 - 8*i -: 8]);
        idle(2);
        check("byte_wins_drops", 128'(PartialDrops), 128'(1));
        check("byte_wins_frame", Frame, D1);

        // Reset mid-frame; data alone must not produce frames afterwards.
        for (int i = 0; i < 9; i++) send_byte(D0[127 - 8*i -: 8]);
        do_reset();
        send_frame(D0, 0);
        send_frame(D1, 1);
        send_frame(D0, 0);
        idle(2);
        check("post_rst_locked", 128'(Locked), '0);
        send_frame(ST_A, 0);

        // Randomised traffic.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 19);
            if (r < 4)       send_frame(rand_status(), ($urandom_range(0, 3) == 0) ? 2 : 0);
            else if (r < 15) send_frame({$urandom, $urandom, $urandom, $urandom},
                                        ($urandom_range(0, 3) == 0) ? 2 : 0);
            else if (r < 17) begin
                repeat ($urandom_range(1, 5)) send_byte(8'($urandom));
            end else if (r < 19) begin
                repeat ($urandom_range(1, 15)) send_byte(8'($urandom));
                idle(($urandom_range(0, 1) == 0) ? int'(IDLE_TIMEOUT) + $urandom_range(0, 3)
                                                 : $urandom_range(0, 20));
            end else begin
                repeat ($urandom_range(1, 12)) send_byte(8'($urandom));
                do_reset();
            end
        end

        idle(4);
        check("drain_queue", 128'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
